// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for a multicycle MIPS-subset datapath
//                (lw, sw, R-type, beq, j, addi). Moore-decoded controls,
//                except IRWrite/PCWrite in FETCH, which follow mem_ready.
//                Also counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,          // asynchronous, active-low
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                halted,
    output logic [CNT_W-1:0]    instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] c_OP_RTYP = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] c_OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] c_OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] c_OP_ADDI = OPCODE_W'(6'b001000);

    state_t r_state;
    state_t w_next_state;
    logic   w_retire;

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Next-state, retire strobe and Moore-decoded datapath controls
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUOp        = 2'b00;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (Opcode == c_OP_LW || Opcode == c_OP_SW) begin
                    w_next_state = S_MEMADR;
                end else if (Opcode == c_OP_RTYP) begin
                    w_next_state = S_EXEC;
                end else if (Opcode == c_OP_BEQ) begin
                    w_next_state = S_BRANCH;
                end else if (Opcode == c_OP_J) begin
                    w_next_state = S_JUMP;
                end else if (Opcode == c_OP_ADDI) begin
                    w_next_state = S_ADDIEX;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = (Opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_next_state = S_RWB;
            end
            S_RWB: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JUMP: begin
                PCWrite      = 1'b1;
                PCSource     = 2'b10;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                // Unused encodings fall into HALT rather than wander.
                w_next_state = S_HALT;
            end
        endcase

        // While reset is held the FSM sits in FETCH; keep every strobe quiet
        // so no memory or register write can leak out during reset.
        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
        end
    end

    assign state  = r_state;
    assign halted = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//                A 4-bit counter instance keeps the wrap case reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    localparam int OPCODE_W = 6;
    localparam int CNT_W    = 4;

    logic                clk;
    logic                rst;
    logic [OPCODE_W-1:0] Opcode;
    logic                mem_ready;
    logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic                MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]          ALUOp, ALUSrcB, PCSource;
    logic [3:0]          state;
    logic                halted;
    logic [CNT_W-1:0]    instret;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(
        .OPCODE_W (OPCODE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .state       (state),
        .halted      (halted),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All 16 control bits packed, MSB first.
    logic [15:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUOp, ALUSrcB, PCSource};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        mem_ready = 1'b0;
        Opcode    = 6'b000000;
        #12;
        // ---- reset state
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_ctl",     32'(ctl),     32'h0000);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_instret", 32'(instret), 32'd0);

        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        // ---- FETCH after reset: MemRead, ALUSrcB=01, IRWrite/PCWrite=mem_ready
        chk("fetch_ctl", 32'(ctl), 32'b1001_0100_0000_0100);

        // ---- R-type: 0,1,6,7,0
        step(); chk("r_decode", 32'(state), 32'd1);
        chk("r_decode_ctl", 32'(ctl), 32'b0000_0000_0000_1100);
        step(); chk("r_exec", 32'(state), 32'd6);
        chk("r_exec_ctl", 32'(ctl), 32'b0000_0000_0110_0000);
        step(); chk("r_rwb", 32'(state), 32'd7);
        chk("r_rwb_ctl", 32'(ctl), 32'b0000_0001_1000_0000);
        step(); chk("r_back", 32'(state), 32'd0);
        chk("r_instret", 32'(instret), 32'd1);

        // ---- lw with two MEMRD wait cycles: 0,1,2,3,3,3,4,0
        Opcode = 6'b100011;
        step(); chk("lw_decode", 32'(state), 32'd1);
        step(); chk("lw_memadr", 32'(state), 32'd2);
        chk("lw_memadr_ctl", 32'(ctl), 32'b0000_0000_0100_1000);
        mem_ready = 1'b0;
        step(); chk("lw_memrd1", 32'(state), 32'd3);
        chk("lw_memrd1_ctl", 32'(ctl), 32'b0011_0000_0000_0000);
        step(); chk("lw_memrd2", 32'(state), 32'd3);
        step(); chk("lw_memrd3", 32'(state), 32'd3);
        chk("lw_memrd3_ctl", 32'(ctl), 32'b0011_0000_0000_0000);
        mem_ready = 1'b1;
        step(); chk("lw_memwb", 32'(state), 32'd4);
        chk("lw_memwb_ctl", 32'(ctl), 32'b0000_0010_1000_0000);
        chk("lw_noretire_yet", 32'(instret), 32'd1);
        step(); chk("lw_back", 32'(state), 32'd0);
        chk("lw_instret", 32'(instret), 32'd2);

        // ---- sw with three FETCH wait cycles
        Opcode    = 6'b101011;
        mem_ready = 1'b0;
        #1;
        chk("sw_fetch1_ir", 32'({IRWrite, PCWrite}), 32'b00);
        step(); chk("sw_fetch2_ir", 32'({IRWrite, PCWrite}), 32'b00);
        step(); chk("sw_fetch3_ir", 32'({IRWrite, PCWrite}), 32'b00);
        chk("sw_fetch3_state", 32'(state), 32'd0);
        step();
        mem_ready = 1'b1;
        #1;
        chk("sw_fetch4_ir", 32'({IRWrite, PCWrite}), 32'b11);
        step(); chk("sw_decode", 32'(state), 32'd1);
        step(); chk("sw_memadr", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step(); chk("sw_memwr", 32'(state), 32'd5);
        chk("sw_memwr_ctl", 32'(ctl), 32'b0010_1000_0000_0000);
        step(); chk("sw_memwr_hold", 32'(instret), 32'd2);
        mem_ready = 1'b1;
        step(); chk("sw_back", 32'(state), 32'd0);
        chk("sw_instret", 32'(instret), 32'd3);

        // ---- beq then j
        Opcode = 6'b000100;
        step(); step(); chk("beq_state", 32'(state), 32'd8);
        chk("beq_ctl", 32'(ctl), 32'b0100_0000_0101_0001);
        Opcode = 6'b000010;
        step(); chk("beq_instret", 32'(instret), 32'd4);
        step(); step(); chk("j_state", 32'(state), 32'd9);
        chk("j_ctl", 32'(ctl), 32'b1000_0000_0000_0010);
        step(); chk("j_instret", 32'(instret), 32'd5);

        // ---- addi
        Opcode = 6'b001000;
        step(); step(); chk("addi_ex", 32'(state), 32'd10);
        chk("addi_ex_ctl", 32'(ctl), 32'b0000_0000_0100_1000);
        step(); chk("addi_wb", 32'(state), 32'd11);
        chk("addi_wb_ctl", 32'(ctl), 32'b0000_0000_1000_0000);
        step(); chk("addi_instret", 32'(instret), 32'd6);

        // ---- reset asserted mid-MEMWR
        Opcode = 6'b101011;
        step(); step();
        mem_ready = 1'b0;
        step(); chk("abort_memwr", 32'(state), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_state",   32'(state),   32'd0);
        chk("abort_ctl",     32'(ctl),     32'h0000);
        chk("abort_instret", 32'(instret), 32'd0);
        step(); step();
        chk("abort_hold_instret", 32'(instret), 32'd0);
        rst       = 1'b1;
        mem_ready = 1'b1;

        // ---- counter wrap: 15 jumps to all-ones, one more to zero
        Opcode = 6'b000010;
        for (int i = 0; i < 15; i++) begin
            step(); step(); step();
        end
        chk("wrap_full", 32'(instret), 32'd15);
        step(); step(); step();
        chk("wrap_zero", 32'(instret), 32'd0);

        // ---- illegal opcode -> HALT forever
        Opcode = 6'b111111;
        step(); chk("halt_decode", 32'(state), 32'd1);
        step(); chk("halt_state", 32'(state), 32'd15);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_ctl", 32'(ctl), 32'h0000);
        mem_ready = 1'b0;
        step();
        mem_ready = 1'b1;
        step(); step();
        chk("halt_stay", 32'(state), 32'd15);
        chk("halt_stay_ctl", 32'(ctl), 32'h0000);
        chk("halt_instret", 32'(instret), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_flag", 32'(halted), 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("post_halt_fetch", 32'(ctl), 32'b1001_0100_0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
